// File: rtl/multicycle_control.sv
// multicycle_control
//
// Control unit for a multicycle MIPS datapath. Each instruction is sequenced
// through fetch, decode, execute, memory and writeback. On every cycle the
// unit drives the shared-datapath mux selects and the write enables.
//
// It also provides:
//   - a mem_ready handshake, with a timeout, on every memory access
//   - illegal-opcode detection
//   - a one-cycle done pulse at the end of each instruction
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous, active-low reset
//   OP, funct      opcode / function fields from IR
//   mem_ready      memory completes the current access this cycle
//   PCWrite        unconditional PC load
//   PCWriteCondEQ  PC load if ALU zero
//   PCWriteCondNE  PC load if ALU not zero
//   IorD           memory address select (0 = PC, 1 = ALUOut)
//   MemRead        memory read strobe
//   MemWrite       memory write strobe
//   IRWrite        IR load
//   RegDst         write register select (0 = rt, 1 = rd)
//   MemtoReg       write data select (0 = ALUOut, 1 = MDR)
//   RegWrite       register file write
//   Jal            forces write register 31 with write data PC
//   ALUSrcA        0 = PC, 1 = A
//   ALUSrcB        00 = B, 01 = 4, 10 = immediate, 11 = immediate<<2
//   PCSource       00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (jr)
//   ALUOp          ALU operation code (zero-extended to ALUOP_WIDTH)
//   state          current state encoding, for debug
//   instr_done     pulse on the final cycle of an instruction
//   mem_err        pulse on a mem_ready timeout
//   illegal_op     pulse while in ILLEGAL
module multicycle_control #(
   parameter int ALUOP_WIDTH = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             OP,
   input  logic [5:0]             funct,
   input  logic                   mem_ready,
   output logic                   PCWrite,
   output logic                   PCWriteCondEQ,
   output logic                   PCWriteCondNE,
   output logic                   IorD,
   output logic                   MemRead,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic                   RegDst,
   output logic                   MemtoReg,
   output logic                   RegWrite,
   output logic                   Jal,
   output logic                   ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [1:0]             PCSource,
   output logic [ALUOP_WIDTH-1:0] ALUOp,
   output logic [3:0]             state,
   output logic                   instr_done,
   output logic                   mem_err,
   output logic                   illegal_op
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_EXEC_I    = 4'd10,
      S_I_WB      = 4'd11,
      S_JR        = 4'd12,
      S_JAL       = 4'd13,
      S_ILLEGAL   = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [3:0] ALU_R    = 4'b0111;
   localparam logic [3:0] ALU_ADD  = 4'b0100;
   localparam logic [3:0] ALU_ANDI = 4'b0101;
   localparam logic [3:0] ALU_ORI  = 4'b0110;
   localparam logic [3:0] ALU_LUI  = 4'b0011;
   localparam logic [3:0] ALU_BEQ  = 4'b1000;
   localparam logic [3:0] ALU_BNE  = 4'b1001;
   localparam logic [3:0] ALU_LW   = 4'b1010;
   localparam logic [3:0] ALU_SW   = 4'b1011;
   localparam logic [3:0] ALU_J    = 4'b0001;
   localparam logic [3:0] ALU_JAL  = 4'b0010;

   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MEM_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [5:0]           op_q, op_d;
   logic [5:0]           funct_q, funct_d;
   logic                 waiting;
   logic                 timeout;
   logic [3:0]           alu_op;

   // A memory-facing state is stalled whenever mem_ready is low.
   // Reaching the limit while stalled abandons the access.
   // A late mem_ready on the limit cycle still wins, because it clears
   // waiting.
   assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE)) && !mem_ready;
   assign timeout = waiting && (cnt_q == CNT_LIMIT);

   assign state = state_q;
   assign ALUOp = ALUOP_WIDTH'(alu_op);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         funct_q <= funct_d;
      end
   end

   // Next-state logic.
   // DECODE routes on the live IR fields, because the latched copy only
   // becomes valid after this edge.
   // The counter only runs while stalled; stalls never coincide with a
   // state change, so leaving a state always clears the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      op_d    = op_q;
      funct_d = funct_q;
      if (waiting && !timeout) begin
         cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d    = OP;
            funct_d = funct;
            case (OP)
               OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
               OP_RTYPE:                          state_d = (funct == FN_JR) ? S_JR : S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
               OP_J:                              state_d = S_JUMP;
               OP_JAL:                            state_d = S_JAL;
               default:                           state_d = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_EXEC_R:    state_d = S_R_WB;
         S_EXEC_I:    state_d = S_I_WB;
         default:     state_d = S_FETCH;
      endcase
      if (timeout) begin
         state_d = S_FETCH;
      end
   end

   // Output decode.
   // The outputs are Moore, except that the FETCH loads and the
   // MEM_WRITE done pulse are qualified by mem_ready.
   // A timeout cycle suppresses every write enable.
   always_comb begin
      PCWrite       = 1'b0;
      PCWriteCondEQ = 1'b0;
      PCWriteCondNE = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      Jal           = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSource      = 2'b00;
      alu_op        = 4'b0000;
      instr_done    = 1'b0;
      mem_err       = timeout;
      illegal_op    = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            alu_op  = ALU_ADD;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            alu_op  = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            alu_op  = (op_q == OP_SW) ? ALU_SW : ALU_LW;
         end
         S_MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite   = !timeout;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            alu_op  = ALU_R;
         end
         S_R_WB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (op_q)
               OP_ANDI: alu_op = ALU_ANDI;
               OP_ORI:  alu_op = ALU_ORI;
               OP_LUI:  alu_op = ALU_LUI;
               default: alu_op = ALU_ADD;
            endcase
         end
         S_I_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA       = 1'b1;
            PCSource      = 2'b01;
            alu_op        = (op_q == OP_BEQ) ? ALU_BEQ : ALU_BNE;
            PCWriteCondEQ = (op_q == OP_BEQ);
            PCWriteCondNE = (op_q == OP_BNE);
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            alu_op     = ALU_J;
            instr_done = 1'b1;
         end
         S_JAL: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            RegWrite   = 1'b1;
            Jal        = 1'b1;
            alu_op     = ALU_JAL;
            instr_done = 1'b1;
         end
         S_JR: begin
            // JR is only reachable with the jr function code latched.
            // Qualifying the PC load on it stops a corrupted latch from
            // redirecting the PC.
            PCWrite    = (funct_q == FN_JR);
            PCSource   = 2'b11;
            instr_done = 1'b1;
         end
         S_ILLEGAL: begin
            illegal_op = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle MIPS control unit. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback, and drives the shared-datapath mux selects and write enables on every cycle. It supports the existing instruction set plus jr, and adds a mem_ready handshake with timeout, illegal-opcode detection, and a per-instruction done pulse. It sits beside the multicycle datapath (PC, IR, MDR, A/B, ALUOut registers) and the unified instruction/data memory.

Parameters:
ALUOP_WIDTH, 4, width of ALUOp; must be >= 4; codes are zero-extended.
MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in one memory state; must be >= 1.
CNT_WIDTH, 4, width of the wait counter; must satisfy 2^CNT_WIDTH > MEM_TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
OP  input  6  opcode field from IR.
funct  input  6  function field from IR.
mem_ready  input  1  memory completes the current access this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCondEQ  output  1  PC load if ALU zero.
PCWriteCondNE  output  1  PC load if ALU not zero.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  IR load.
RegDst  output  1  write register select: 0 = rt, 1 = rd.
MemtoReg  output  1  write data select: 0 = ALUOut, 1 = MDR.
RegWrite  output  1  register file write.
Jal  output  1  forces write register 31 and write data PC.
ALUSrcA  output  1  0 = PC, 1 = A.
ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign/zero-extended immediate, 11 = immediate<<2.
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (jr).
ALUOp  output  ALUOP_WIDTH  ALU operation code.
state  output  4  current state encoding, for debug.
instr_done  output  1  one-cycle pulse on the final cycle of an instruction.
mem_err  output  1  one-cycle pulse on mem_ready timeout.
illegal_op  output  1  one-cycle pulse while in ILLEGAL.

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, wait counter=0, latched OP/funct=0. All outputs follow from FETCH with mem_ready low: MemRead=1, ALUSrcB=01, ALUOp=0100. All other outputs are 0.
- Outputs are combinational from state, latched OP/funct, and mem_ready. Moore except the gating noted for mem_ready.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11, JR=12, JAL=13, ILLEGAL=14.
- ALUOp codes: R=0111, ADDI/PC+4=0100, ANDI=0101, ORI=0110, LUI=0011, BEQ=1000, BNE=1001, LW=1010, SW=1011, J=0001, JAL=0010.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00. IRWrite and PCWrite equal mem_ready. Go to DECODE when mem_ready=1.
- DECODE: latch OP/funct. ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R-type with funct 001000 -> JR
  - other R-type -> EXEC_R
  - ADDI/ANDI/ORI/LUI -> EXEC_I
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - JAL -> JAL
  - anything else -> ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=LW or SW code. Go to MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: MemRead=1, IorD=1. Go to MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready: instr_done=1, go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=0111. Go to R_WB.
- R_WB: RegWrite=1, RegDst=1, instr_done=1. Go to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp from the latched opcode. Go to I_WB.
- I_WB: RegWrite=1, RegDst=0, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, PCSource=01, ALUOp=1000/1001. PCWriteCondEQ (BEQ) or PCWriteCondNE (BNE) set. instr_done=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10, ALUOp=0001, instr_done=1. Go to FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, Jal=1, ALUOp=0010, instr_done=1. Go to FETCH.
- JR: PCWrite=1, PCSource=11, instr_done=1. Go to FETCH.
- ILLEGAL: illegal_op=1, all write enables 0. Go to FETCH.
- Wait counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while mem_ready=0.
  - Clears on any state change or when mem_ready=1.
  - If the counter equals MEM_TIMEOUT-1 with mem_ready=0: mem_err=1, counter clears, state goes to FETCH (re-fetch from the unchanged PC). No write enables assert that cycle.
- mem_ready asserted in the same cycle as the timeout: the access completes normally and mem_err=0.
- Reset mid-instruction: immediate return to FETCH; a pending write enable drops asynchronously.

Test Plan:
- Reset low for 3 cycles, then high with mem_ready=1 always and OP=000000, funct=100000: states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_done pulses once per 4 cycles.
- LW (OP=100011), mem_ready low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0; MemRead=1 and IorD=1 across state 3; MemtoReg=1 and RegWrite=1 in state 4.
- BNE (OP=000101): BRANCH state with PCWriteCondNE=1, PCWriteCondEQ=0, PCSource=01, ALUOp=1001. JAL (OP=000011): Jal=1, RegWrite=1, PCSource=10, ALUOp=0010.
- OP=000000, funct=001000: JR state with PCSource=11, PCWrite=1, RegWrite=0. OP=111111: ILLEGAL state, illegal_op pulses for 1 cycle, no writes, returns to FETCH.
- mem_ready held low in FETCH: mem_err pulses on the 15th waiting cycle, state stays FETCH, IRWrite and PCWrite stay 0; repeats every 15 cycles.
- SW with reset asserted while in MEM_WRITE: MemWrite drops to 0 immediately; after release, state=0 and ALUOp=0100.
